sram_1r1w_init: RTL and testbench

Behavioural two-port (one read, one write) SRAM model with a parametrised read pipeline, per-bit write mask, write-first collision bypass and a hardware clear-on-reset sequencer. It is the next-generation macro model for the nangate45 memory wrappers, replacing single-port 1rw models where a read and a write must issue in the same cycle. It is a simulation model; timing closure uses the matching fakeram LEF/LIB.

---
 rtl/sram_1r1w_init.sv | 131 +++++++++++++
 tb/tb_sram_1r1w_init.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_init.sv
// Behavioural one-read/one-write SRAM with masked writes, write-first bypass,
// a 1..N stage read pipeline and an optional clear-after-reset sequencer.
module sram_1r1w_init #(
    parameter int BITS               = 96,
    parameter int WORD_DEPTH         = 4096,
    parameter int ADDR_WIDTH         = 12,
    parameter int READ_LATENCY       = 1,
    parameter bit INIT_ON_RESET      = 1'b1,
    parameter bit corrupt_mem_on_X_p = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_in,
    output logic                  ready_out,
    input  logic                  rd_ce_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    input  logic                  wr_ce_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in
);

    localparam int                    IDX_W     = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORD_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_READY
    } state_e;

    state_e           state;
    state_e           state_next;
    logic [IDX_W-1:0] init_cnt;

    logic [BITS-1:0]  mem [WORD_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_in_range;
    logic             wr_in_range;
    logic             rd_fire;
    logic [BITS-1:0]  wr_merged;
    logic [BITS-1:0]  rd_word;

    logic [BITS-1:0]         pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    assign rd_idx      = rd_addr_in[IDX_W-1:0];
    assign wr_idx      = wr_addr_in[IDX_W-1:0];
    assign rd_in_range = {1'b0, rd_addr_in} < DEPTH_LIM;
    assign wr_in_range = {1'b0, wr_addr_in} < DEPTH_LIM;
    assign ready_out   = (state == ST_READY);
    assign rd_fire     = ready_out & rd_ce_in;
    assign wr_merged   = (wd_in & w_mask_in) | (mem[wr_idx] & ~w_mask_in);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state    <= ST_RESET;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = INIT_ON_RESET ? ST_INIT : ST_READY;
            ST_INIT:  if (init_cnt == LAST_IDX) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RESET;
        endcase
    end

    // NOTE: the array itself is never reset; clearing is a sequenced one-word-per-cycle
    // write so the storage still maps onto a plain RAM.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (state == ST_READY) begin
                if (corrupt_mem_on_X_p &&
                    ($isunknown(wr_ce_in) || (wr_ce_in && $isunknown(wr_addr_in)))) begin
                    $warning("sram_1r1w_init: X on write control, array corrupted");
                    for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= 'x;
                end else if (wr_ce_in) begin
                    if (wr_in_range) mem[wr_idx] <= wr_merged;
                    else $warning("sram_1r1w_init: write to address %0d dropped (out of range)",
                                  wr_addr_in);
                end
            end
        end
    end

    // Write-first: a same-cycle write to the read address is bypassed into the read.
    always_comb begin
        rd_word = '0;
        if ($isunknown(rd_addr_in)) begin
            rd_word = 'x;
        end else if (rd_in_range) begin
            if (wr_ce_in && wr_in_range && (wr_addr_in == rd_addr_in)) rd_word = wr_merged;
            else rd_word = mem[rd_idx];
        end
    end

    // Data registers only load with a valid token, so idle cycles hold the last word.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            if (rd_fire) pipe_data[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign rd_out       = pipe_data[READ_LATENCY-1];
    assign rd_valid_out = pipe_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1r1w_init.sv
// Self-checking bench: three configurations of sram_1r1w_init driven with directed
// and random traffic, compared every cycle against a behavioural memory model.
module tb_sram_1r1w_init;

    localparam int ND = 3;

    function automatic int dep_of(int d);
        return (d == 2) ? 12 : 16;
    endfunction
    function automatic int lat_of(int d);
        return (d == 1) ? 2 : 1;
    endfunction
    function automatic bit init_of(int d);
        return (d != 2);
    endfunction

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [ND];
    logic       rd_ce    [ND];
    logic       wr_ce    [ND];
    logic [3:0] rd_addr  [ND];
    logic [3:0] wr_addr  [ND];
    logic [7:0] wd       [ND];
    logic [7:0] wm       [ND];
    logic       ready    [ND];
    logic       rd_valid [ND];
    logic [7:0] rd_data  [ND];

    sram_1r1w_init #(.BITS(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1),
                     .INIT_ON_RESET(1'b1), .corrupt_mem_on_X_p(1'b1)) u_l1 (
        .clk(clk), .rst_in(rst[0]), .ready_out(ready[0]),
        .rd_ce_in(rd_ce[0]), .rd_addr_in(rd_addr[0]), .rd_out(rd_data[0]),
        .rd_valid_out(rd_valid[0]), .wr_ce_in(wr_ce[0]), .wr_addr_in(wr_addr[0]),
        .wd_in(wd[0]), .w_mask_in(wm[0]));

    sram_1r1w_init #(.BITS(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2),
                     .INIT_ON_RESET(1'b1), .corrupt_mem_on_X_p(1'b1)) u_l2 (
        .clk(clk), .rst_in(rst[1]), .ready_out(ready[1]),
        .rd_ce_in(rd_ce[1]), .rd_addr_in(rd_addr[1]), .rd_out(rd_data[1]),
        .rd_valid_out(rd_valid[1]), .wr_ce_in(wr_ce[1]), .wr_addr_in(wr_addr[1]),
        .wd_in(wd[1]), .w_mask_in(wm[1]));

    sram_1r1w_init #(.BITS(8), .WORD_DEPTH(12), .ADDR_WIDTH(4), .READ_LATENCY(1),
                     .INIT_ON_RESET(1'b0), .corrupt_mem_on_X_p(1'b1)) u_oor (
        .clk(clk), .rst_in(rst[2]), .ready_out(ready[2]),
        .rd_ce_in(rd_ce[2]), .rd_addr_in(rd_addr[2]), .rd_out(rd_data[2]),
        .rd_valid_out(rd_valid[2]), .wr_ce_in(wr_ce[2]), .wr_addr_in(wr_addr[2]),
        .wd_in(wd[2]), .w_mask_in(wm[2]));

    // Reference model: contents, known-ness, cycles left until ready, and a list of
    // read results tagged with the cycle they are due on the output.
    logic [7:0] mm         [ND][16];
    bit         mk         [ND][16];
    int         busy       [ND];
    bit         m_ready    [ND];
    int         pend_due   [ND][4];
    logic [7:0] pend_dat   [ND][4];
    bit         pend_known [ND][4];
    int         pend_n     [ND];
    bit         e_valid    [ND];
    logic [7:0] e_data     [ND];
    bit         e_known    [ND];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            if (rst[d]) begin
                busy[d]    = init_of(d) ? dep_of(d) + 1 : 1;
                m_ready[d] = 1'b0;
                pend_n[d]  = 0;
                e_valid[d] = 1'b0;
                e_data[d]  = 8'h00;
                e_known[d] = 1'b1;
            end else begin
                if (m_ready[d]) begin
                    if (wr_ce[d] && int'(wr_addr[d]) < dep_of(d)) begin
                        mm[d][wr_addr[d]] = (wd[d] & wm[d]) | (mm[d][wr_addr[d]] & ~wm[d]);
                        mk[d][wr_addr[d]] = mk[d][wr_addr[d]] || (wm[d] == 8'hFF);
                    end
                    if (rd_ce[d]) begin
                        pend_due[d][pend_n[d]] = cyc + lat_of(d) - 1;
                        if (int'(rd_addr[d]) < dep_of(d)) begin
                            pend_dat[d][pend_n[d]]   = mm[d][rd_addr[d]];
                            pend_known[d][pend_n[d]] = mk[d][rd_addr[d]];
                        end else begin
                            pend_dat[d][pend_n[d]]   = 8'h00;
                            pend_known[d][pend_n[d]] = 1'b1;
                        end
                        pend_n[d]++;
                    end
                end
                if (busy[d] > 0) begin
                    busy[d]--;
                    if (busy[d] == 0) begin
                        m_ready[d] = 1'b1;
                        if (init_of(d))
                            for (int a = 0; a < 16; a++) begin
                                mm[d][a] = 8'h00;
                                mk[d][a] = 1'b1;
                            end
                    end
                end
                e_valid[d] = 1'b0;
                if (pend_n[d] > 0 && pend_due[d][0] == cyc) begin
                    e_valid[d] = 1'b1;
                    e_data[d]  = pend_dat[d][0];
                    e_known[d] = pend_known[d][0];
                    for (int k = 0; k < 3; k++) begin
                        pend_due[d][k]   = pend_due[d][k+1];
                        pend_dat[d][k]   = pend_dat[d][k+1];
                        pend_known[d][k] = pend_known[d][k+1];
                    end
                    pend_n[d]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d ready_out", d), 32'(ready[d]), 32'(m_ready[d]));
            check($sformatf("d%0d rd_valid_out", d), 32'(rd_valid[d]), 32'(e_valid[d]));
            if (e_known[d]) check($sformatf("d%0d rd_out", d), 32'(rd_data[d]), 32'(e_data[d]));
        end
    endtask

    task automatic idle(input int d);
        rd_ce[d] = 1'b0;
        wr_ce[d] = 1'b0;
    endtask

    task automatic wr(input int d, input int a, input logic [7:0] data, input logic [7:0] mask);
        wr_ce[d]   = 1'b1;
        wr_addr[d] = 4'(a);
        wd[d]      = data;
        wm[d]      = mask;
    endtask

    task automatic rd(input int d, input int a);
        rd_ce[d]   = 1'b1;
        rd_addr[d] = 4'(a);
    endtask

    task automatic rand_req(input int d);
        rd_ce[d]   = 1'($urandom_range(0, 1));
        rd_addr[d] = 4'($urandom_range(0, 15));
        wr_ce[d]   = 1'($urandom_range(0, 1));
        wr_addr[d] = 4'($urandom_range(0, dep_of(d) - 1));
        wd[d]      = 8'($urandom);
        wm[d]      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        if ($urandom_range(0, 3) == 0 && int'(rd_addr[d]) < dep_of(d)) wr_addr[d] = rd_addr[d];
    endtask

    int rise_at;

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; idle(d);
            rd_addr[d] = '0; wr_addr[d] = '0; wd[d] = '0; wm[d] = '0;
            pend_n[d] = 0;
            for (int a = 0; a < 16; a++) begin mm[d][a] = 8'h00; mk[d][a] = 1'b0; end
        end
        tick();
        tick();
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;

        // Init sweep with junk requests that must be ignored
        rise_at = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 17) begin
                rand_req(0); rand_req(1);
                wd[0] = wd[0] | 8'h01; wd[1] = wd[1] | 8'h01;
            end else begin
                idle(0); idle(1);
            end
            tick();
            if (ready[0] === 1'b1 && rise_at < 0) rise_at = k;
        end
        idle(0); idle(1);
        check("init_ready_delay", 32'(rise_at), 32'd17);
        for (int a = 0; a < 16; a++) begin rd(0, a); rd(1, a); tick(); end
        idle(0); idle(1); tick(); tick();

        // Masked write then read, checked at the exact latency
        for (int d = 0; d < ND; d++) wr(d, 3, 8'hA5, 8'hFF);
        tick();
        for (int d = 0; d < ND; d++) wr(d, 3, 8'h0F, 8'hF0);
        tick();
        for (int d = 0; d < ND; d++) begin idle(d); rd(d, 3); end
        tick();
        check("mask_l1_data", 32'(rd_data[0]), 32'h05);
        check("mask_l1_valid", 32'(rd_valid[0]), 32'd1);
        check("mask_l2_early", 32'(rd_valid[1]), 32'd0);
        for (int d = 0; d < ND; d++) idle(d);
        tick();
        check("mask_l2_data", 32'(rd_data[1]), 32'h05);
        check("mask_l2_valid", 32'(rd_valid[1]), 32'd1);
        tick();

        // Collision: same-cycle write-first, then read-before-later-write
        for (int d = 0; d < ND; d++) wr(d, 7, 8'h11, 8'hFF);
        tick();
        for (int d = 0; d < ND; d++) begin wr(d, 7, 8'h22, 8'hFF); rd(d, 7); end
        tick();
        check("collide_wf", 32'(rd_data[0]), 32'h22);
        for (int d = 0; d < ND; d++) begin idle(d); rd(d, 7); end
        tick();
        for (int d = 0; d < ND; d++) begin idle(d); wr(d, 7, 8'h33, 8'hFF); end
        tick();
        check("collide_late_write", 32'(rd_data[1]), 32'h22);
        for (int d = 0; d < ND; d++) idle(d);
        tick(); tick();

        // Streaming reads of addr ^ 0x5A
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < ND; d++) begin
                idle(d);
                if (a < dep_of(d)) wr(d, a, 8'(a) ^ 8'h5A, 8'hFF);
            end
            tick();
        end
        for (int d = 0; d < ND; d++) idle(d);
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < ND; d++) rd(d, a);
            tick();
        end
        for (int d = 0; d < ND; d++) idle(d);
        tick(); tick();

        // Out-of-range write/read on the 12-word instance
        wr(2, 13, 8'h77, 8'hFF);
        tick();
        idle(2); rd(2, 13);
        tick();
        check("oor_read_data", 32'(rd_data[2]), 32'h00);
        check("oor_read_valid", 32'(rd_valid[2]), 32'd1);
        for (int a = 0; a < 12; a++) begin rd(2, a); tick(); end
        idle(2); tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < ND; d++) rand_req(d);
            tick();
        end
        for (int d = 0; d < ND; d++) idle(d);
        tick(); tick();

        // Mid-operation reset with reads in flight
        for (int d = 0; d < ND; d++) rd(d, 5);
        tick();
        for (int d = 0; d < ND; d++) rd(d, 6);
        tick();
        for (int d = 0; d < ND; d++) begin idle(d); rst[d] = 1'b1; end
        tick();
        check("rst_l2_valid", 32'(rd_valid[1]), 32'd0);
        check("rst_l2_data", 32'(rd_data[1]), 32'h00);
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        rise_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ready[1] === 1'b1 && rise_at < 0) rise_at = k;
        end
        check("reinit_ready_delay", 32'(rise_at), 32'd17);
        for (int a = 0; a < 16; a++) begin for (int d = 0; d < ND; d++) rd(d, a); tick(); end
        for (int d = 0; d < ND; d++) idle(d);

        for (int k = 0; k < 200; k++) begin
            for (int d = 0; d < ND; d++) rand_req(d);
            tick();
        end
        for (int d = 0; d < ND; d++) idle(d);
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
